miner_job_driver: RTL and testbench
===================================

Name: miner_job_driver

Overview:
- AXI-Stream initiator for the bitcoin miner accelerator; it sits on the opposite end of the miner's stream interfaces.
- On `start` it latches a 640-bit job (block header) and streams it out as 20 32-bit words on its master port, last word flagged with tlast.
- It then collects the 8-word result (256-bit hash) from its slave port and reports it with a one-cycle done pulse and status flags.
- Used as the fabric-side job dispatcher and as the stimulus engine in system benches.

Parameters:
- C_AXIS_TDATA_WIDTH, 32, width of both stream data buses.
- NUMBER_OF_JOB_WORDS, 20, words sent per job.
- NUMBER_OF_RESULT_WORDS, 8, words expected per result.
- RESP_TIMEOUT_CYCLES, 65535, max idle cycles between result beats; 0 disables the timeout.

Ports:
- axis_aclk  in  1  single clock for all logic.
- axis_aresetn  in  1  asynchronous, active-low reset.
- start  in  1  job request; sampled only in IDLE.
- job_data  in  NUMBER_OF_JOB_WORDS*C_AXIS_TDATA_WIDTH  job payload; word j = job_data[j*W +: W].
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse, job complete (normally or on error).
- result  out  NUMBER_OF_RESULT_WORDS*C_AXIS_TDATA_WIDTH  word k = result[k*W +: W]; held until the next accepted start.
- err_len  out  1  tlast mismatch on the result stream; valid with done, held until next start.
- err_timeout  out  1  result timeout occurred; valid with done, held until next start.
- m00_axis_tvalid  out  1  master valid.
- m00_axis_tdata  out  C_AXIS_TDATA_WIDTH  master data.
- m00_axis_tstrb  out  C_AXIS_TDATA_WIDTH/8  constant all ones.
- m00_axis_tlast  out  1  high on job word NUMBER_OF_JOB_WORDS-1.
- m00_axis_tready  in  1  master ready.
- s00_axis_tready  out  1  slave ready.
- s00_axis_tdata  in  C_AXIS_TDATA_WIDTH  slave data.
- s00_axis_tstrb  in  C_AXIS_TDATA_WIDTH/8  ignored.
- s00_axis_tlast  in  1  slave last.
- s00_axis_tvalid  in  1  slave valid.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; all pointers and counters = 0.
  - busy, done, m00_axis_tvalid, m00_axis_tlast, s00_axis_tready, err_len, err_timeout = 0.
  - result = 0; m00_axis_tdata = 0.
  - Reset mid-operation aborts at once: tvalid/tready drop in the same instant and no done pulse is issued.
- States: IDLE -> SEND -> RECV -> DONE -> IDLE.
- IDLE:
  - start = 1: latch job_data into an internal register, clear result / err_len / err_timeout, send_ptr = 0, go to SEND.
  - start in any other state is ignored.
- SEND:
  - m00_axis_tvalid = 1; m00_axis_tdata = latched word[send_ptr]; m00_axis_tlast = (send_ptr == NUMBER_OF_JOB_WORDS-1).
  - tvalid, tdata and tlast come from registers only; there is no combinational path from tready. They are stable while tvalid && !tready.
  - Each beat (tvalid && tready) increments send_ptr.
  - Beat on the last word: go to RECV with recv_ptr = 0 and the timeout counter = 0. tvalid is low in the following cycle.
  - Latency: start in cycle 0 -> first tvalid in cycle 1. With tready held high, the 20 beats occupy cycles 1..20.
- RECV:
  - s00_axis_tready = 1.
  - Each beat stores s00_axis_tdata into result word recv_ptr and clears the timeout counter.
  - Beat with tlast = 1 and recv_ptr < NUMBER_OF_RESULT_WORDS-1: set err_len, go to DONE. Words not received stay 0.
  - Beat at recv_ptr == NUMBER_OF_RESULT_WORDS-1: go to DONE. If tlast = 0 on that beat, set err_len; any trailing words are left unaccepted.
  - No beat: the timeout counter increments. When it reaches RESP_TIMEOUT_CYCLES (nonzero), set err_timeout and go to DONE.
  - A beat in the same cycle as the timeout threshold wins: it is accepted and no timeout is flagged.
- DONE:
  - done = 1 for exactly one cycle; s00_axis_tready = 0; next state IDLE.
  - busy falls with the return to IDLE. A start in the cycle after done is accepted.
- The result width is exact: no byte swapping, word order as the port mapping above.

Test Plan:
- Nominal job:
  - Stimulus: job word j = 0x1000_0000+j, tready held high; slave responder returns 0xA0..0xA7 with tlast on the 8th word.
  - Required: tvalid in cycles 1..20, tlast only on word 0x1000_0013, done pulse 1 cycle after the 8th result beat, result[31:0] = 0xA0, result[255:224] = 0xA7, both error flags 0.
- Master backpressure:
  - Stimulus: tready toggles 1,0,0,1 pseudo-randomly.
  - Required: tdata/tlast held stable during stalls, exactly 20 beats in order, no duplicated or skipped word.
- Short result:
  - Stimulus: responder sends 5 words, tlast on the 5th.
  - Required: done pulse, err_len = 1, result words 5..7 = 0.
- Missing tlast:
  - Stimulus: 8 result words with no tlast.
  - Required: done after the 8th beat, err_len = 1, s00_axis_tready = 0 afterwards.
- Timeout:
  - Stimulus: RESP_TIMEOUT_CYCLES = 16, responder silent after 3 words.
  - Required: done 16 cycles after the 3rd beat, err_timeout = 1.
  - Also: a beat in the threshold cycle gives no timeout.
- Reset and start handling:
  - Stimulus: aresetn low mid-SEND (after 7 beats), then a new start.
  - Required: tvalid drops immediately, busy = 0, no done pulse; the next job starts from word 0.
  - Also: a start pulsed during RECV is ignored.

Source files
------------

// File: rtl/miner_job_driver.sv
// -----------------------------------------------------------------------------
// miner_job_driver
//
// Fabric-side job dispatcher for the bitcoin miner accelerator. On a start
// request in IDLE it latches a block header (NUMBER_OF_JOB_WORDS words) and
// streams it out on the m00 AXI-Stream master, tlast on the final word. It
// then collects NUMBER_OF_RESULT_WORDS words from the s00 AXI-Stream slave,
// flags tlast mismatches and response timeouts, and pulses done for one cycle.
//
// Ports:
//   axis_aclk, axis_aresetn       clock, asynchronous active-low reset
//   start, job_data               job request (sampled in IDLE) and payload,
//                                 word j = job_data[j*W +: W]
//   busy, done                    busy while not IDLE, one-cycle completion
//   result, err_len, err_timeout  collected hash (word k = result[k*W +: W])
//                                 and error flags, held until the next start
//   m00_axis_*                    job stream out (tstrb constant all ones)
//   s00_axis_*                    result stream in (tstrb ignored)
// -----------------------------------------------------------------------------
module miner_job_driver #(
    parameter int C_AXIS_TDATA_WIDTH     = 32,
    parameter int NUMBER_OF_JOB_WORDS    = 20,
    parameter int NUMBER_OF_RESULT_WORDS = 8,
    parameter int RESP_TIMEOUT_CYCLES    = 65535
) (
    input  logic                                                 axis_aclk,
    input  logic                                                 axis_aresetn,
    input  logic                                                 start,
    input  logic [NUMBER_OF_JOB_WORDS*C_AXIS_TDATA_WIDTH-1:0]    job_data,
    output logic                                                 busy,
    output logic                                                 done,
    output logic [NUMBER_OF_RESULT_WORDS*C_AXIS_TDATA_WIDTH-1:0] result,
    output logic                                                 err_len,
    output logic                                                 err_timeout,
    output logic                                                 m00_axis_tvalid,
    output logic [C_AXIS_TDATA_WIDTH-1:0]                        m00_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0]                      m00_axis_tstrb,
    output logic                                                 m00_axis_tlast,
    input  logic                                                 m00_axis_tready,
    output logic                                                 s00_axis_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]                        s00_axis_tdata,
    input  logic [C_AXIS_TDATA_WIDTH/8-1:0]                      s00_axis_tstrb,
    input  logic                                                 s00_axis_tlast,
    input  logic                                                 s00_axis_tvalid
);

    localparam int W    = C_AXIS_TDATA_WIDTH;
    localparam int NJ   = NUMBER_OF_JOB_WORDS;
    localparam int NR   = NUMBER_OF_RESULT_WORDS;
    localparam int SP_W = (NJ > 1) ? $clog2(NJ) : 1;
    localparam int RP_W = (NR > 1) ? $clog2(NR) : 1;

    localparam logic [SP_W-1:0] LAST_JOB_PTR  = SP_W'(NJ - 1);
    localparam logic [RP_W-1:0] LAST_RES_PTR  = RP_W'(NR - 1);
    localparam logic [31:0]     TIMEOUT_LIMIT = 32'(RESP_TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_RECV,
        ST_DONE
    } state_t;

    state_t            r_state, w_state_next;
    logic [SP_W-1:0]   r_send_ptr, w_send_ptr_next;
    logic [RP_W-1:0]   r_recv_ptr, w_recv_ptr_next;
    logic [31:0]       r_timeout_cnt, w_timeout_cnt_next;
    logic              r_err_len, w_err_len_next;
    logic              r_err_timeout, w_err_timeout_next;
    logic              w_load_job;
    logic              w_store_result;
    logic              w_m_beat;
    logic              w_s_beat;
    logic              w_unused;

    logic [W-1:0]      r_job    [NJ];
    logic [W-1:0]      r_result [NR];

    assign w_m_beat = (r_state == ST_SEND) && m00_axis_tready;
    assign w_s_beat = (r_state == ST_RECV) && s00_axis_tvalid;

    // Result-stream byte strobes carry no information for this block.
    assign w_unused = ^s00_axis_tstrb;

    // State and control registers.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            r_state       <= ST_IDLE;
            r_send_ptr    <= '0;
            r_recv_ptr    <= '0;
            r_timeout_cnt <= '0;
            r_err_len     <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_send_ptr    <= w_send_ptr_next;
            r_recv_ptr    <= w_recv_ptr_next;
            r_timeout_cnt <= w_timeout_cnt_next;
            r_err_len     <= w_err_len_next;
            r_err_timeout <= w_err_timeout_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_send_ptr_next    = r_send_ptr;
        w_recv_ptr_next    = r_recv_ptr;
        w_timeout_cnt_next = r_timeout_cnt;
        w_err_len_next     = r_err_len;
        w_err_timeout_next = r_err_timeout;
        w_load_job         = 1'b0;
        w_store_result     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load_job         = 1'b1;
                    w_send_ptr_next    = '0;
                    w_recv_ptr_next    = '0;
                    w_timeout_cnt_next = '0;
                    w_err_len_next     = 1'b0;
                    w_err_timeout_next = 1'b0;
                    w_state_next       = ST_SEND;
                end
            end

            ST_SEND: begin
                if (w_m_beat) begin
                    if (r_send_ptr == LAST_JOB_PTR) begin
                        // Pointer parks at 0 so tdata never indexes past the job.
                        w_send_ptr_next    = '0;
                        w_recv_ptr_next    = '0;
                        w_timeout_cnt_next = '0;
                        w_state_next       = ST_RECV;
                    end else begin
                        w_send_ptr_next = r_send_ptr + 1'b1;
                    end
                end
            end

            ST_RECV: begin
                if (w_s_beat) begin
                    // A beat always wins over the timeout threshold.
                    w_store_result     = 1'b1;
                    w_timeout_cnt_next = '0;
                    if (r_recv_ptr == LAST_RES_PTR) begin
                        w_err_len_next = !s00_axis_tlast;
                        w_state_next   = ST_DONE;
                    end else if (s00_axis_tlast) begin
                        w_err_len_next = 1'b1;
                        w_state_next   = ST_DONE;
                    end else begin
                        w_recv_ptr_next = r_recv_ptr + 1'b1;
                    end
                end else if (TIMEOUT_LIMIT != 32'd0) begin
                    // Fires on the RESP_TIMEOUT_CYCLES-th consecutive idle cycle.
                    if (r_timeout_cnt + 32'd1 == TIMEOUT_LIMIT) begin
                        w_err_timeout_next = 1'b1;
                        w_state_next       = ST_DONE;
                    end else begin
                        w_timeout_cnt_next = r_timeout_cnt + 32'd1;
                    end
                end
            end

            ST_DONE: begin
                w_state_next = ST_IDLE;
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Job and result word storage.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            for (int j = 0; j < NJ; j++) r_job[j] <= '0;
            for (int k = 0; k < NR; k++) r_result[k] <= '0;
        end else begin
            if (w_load_job) begin
                for (int j = 0; j < NJ; j++) r_job[j] <= job_data[j*W +: W];
                for (int k = 0; k < NR; k++) r_result[k] <= '0;
            end else if (w_store_result) begin
                r_result[r_recv_ptr] <= s00_axis_tdata;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NR; gi++) begin : g_result
            assign result[gi*W +: W] = r_result[gi];
        end
    endgenerate

    // Stream outputs are decoded from registered state only (no tready path).
    assign busy            = (r_state != ST_IDLE);
    assign done            = (r_state == ST_DONE);
    assign err_len         = r_err_len;
    assign err_timeout     = r_err_timeout;
    assign m00_axis_tvalid = (r_state == ST_SEND);
    assign m00_axis_tdata  = (r_state == ST_SEND) ? r_job[r_send_ptr] : '0;
    assign m00_axis_tlast  = (r_state == ST_SEND) && (r_send_ptr == LAST_JOB_PTR);
    assign m00_axis_tstrb  = '1;
    assign s00_axis_tready = (r_state == ST_RECV);

endmodule

// File: tb/tb_miner_job_driver.sv
// -----------------------------------------------------------------------------
// tb_miner_job_driver
//
// Directed + randomized bench for miner_job_driver (timeout set to 16 cycles).
// Each job: random or counting header, random or constant master tready, and a
// responder plan (word, tlast, idle gap before the word). The expected result,
// error flags and number of RECV cycles come from a plan-level model.
// -----------------------------------------------------------------------------
module tb_miner_job_driver;

    localparam int W  = 32;
    localparam int NJ = 20;
    localparam int NR = 8;
    localparam int T  = 16;

    logic              clk = 1'b0;
    logic              aresetn;
    logic              start;
    logic [NJ*W-1:0]   job_data;
    logic              busy;
    logic              done;
    logic [NR*W-1:0]   result;
    logic              err_len;
    logic              err_timeout;
    logic              m_tvalid;
    logic [W-1:0]      m_tdata;
    logic [W/8-1:0]    m_tstrb;
    logic              m_tlast;
    logic              m_tready;
    logic              s_tready;
    logic [W-1:0]      s_tdata;
    logic [W/8-1:0]    s_tstrb;
    logic              s_tlast;
    logic              s_tvalid;

    always #5 clk = ~clk;

    miner_job_driver #(
        .C_AXIS_TDATA_WIDTH    (W),
        .NUMBER_OF_JOB_WORDS   (NJ),
        .NUMBER_OF_RESULT_WORDS(NR),
        .RESP_TIMEOUT_CYCLES   (T)
    ) dut (
        .axis_aclk      (clk),
        .axis_aresetn   (aresetn),
        .start          (start),
        .job_data       (job_data),
        .busy           (busy),
        .done           (done),
        .result         (result),
        .err_len        (err_len),
        .err_timeout    (err_timeout),
        .m00_axis_tvalid(m_tvalid),
        .m00_axis_tdata (m_tdata),
        .m00_axis_tstrb (m_tstrb),
        .m00_axis_tlast (m_tlast),
        .m00_axis_tready(m_tready),
        .s00_axis_tready(s_tready),
        .s00_axis_tdata (s_tdata),
        .s00_axis_tstrb (s_tstrb),
        .s00_axis_tlast (s_tlast),
        .s00_axis_tvalid(s_tvalid)
    );

    int checks = 0;
    int errors = 0;

    logic [W-1:0]    job_w [NJ];
    logic [W-1:0]    plan_data[$];
    bit              plan_last[$];
    int              plan_gap[$];
    bit              tready_random;
    logic [NR*W-1:0] held_res;
    logic            held_elen;
    logic            held_to;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_job(input bit counting);
        for (int j = 0; j < NJ; j++)
            job_w[j] = counting ? (32'h1000_0000 + 32'(j)) : 32'($urandom);
    endtask

    task automatic clear_plan();
        plan_data.delete();
        plan_last.delete();
        plan_gap.delete();
    endtask

    task automatic add_beat(input logic [W-1:0] d, input bit l, input int g);
        plan_data.push_back(d);
        plan_last.push_back(l);
        plan_gap.push_back(g);
    endtask

    // Plan-level model: walk the responder's words, apply the length and
    // timeout rules, and total the cycles the DUT should spend in RECV.
    task automatic model(output logic [NR*W-1:0] res, output logic elen,
                         output logic to, output int cycles);
        int  k;
        bit  fin;
        res = '0; elen = 1'b0; to = 1'b0; cycles = 0; k = 0; fin = 1'b0;
        for (int i = 0; i < plan_data.size() && !fin; i++) begin
            if (plan_gap[i] >= T) begin
                cycles += T; to = 1'b1; fin = 1'b1;
            end else begin
                cycles += plan_gap[i] + 1;
                res[k*W +: W] = plan_data[i];
                if (k == NR - 1) begin
                    elen = !plan_last[i]; fin = 1'b1;
                end else if (plan_last[i]) begin
                    elen = 1'b1; fin = 1'b1;
                end
                k++;
            end
        end
        if (!fin) begin
            cycles += T; to = 1'b1;
        end
    endtask

    // One job: start in cycle 0, then drive/observe at every falling edge.
    task automatic run_job(input int abort_after, input bit poke_recv);
        logic [NR*W-1:0] e_res;
        logic            e_elen, e_to;
        int              e_cycles;
        int              cyc, mbeats, recv_cycles, pi, idle, last_beat_cyc;
        bit              prev_stall, seen_done;
        logic [W-1:0]    prev_data;
        logic            prev_last;

        model(e_res, e_elen, e_to, e_cycles);
        cyc = 0; mbeats = 0; recv_cycles = 0; pi = 0; idle = 0; last_beat_cyc = 0;
        prev_stall = 1'b0; seen_done = 1'b0; prev_data = '0; prev_last = 1'b0;

        @(negedge clk);
        chk("idle_busy",     256'(busy), 256'(0));
        chk("idle_done",     256'(done), 256'(0));
        chk("idle_s_tready", 256'(s_tready), 256'(0));
        chk("idle_m_tvalid", 256'(m_tvalid), 256'(0));
        chk("held_result",   256'(result), 256'(held_res));
        chk("held_err_len",  256'(err_len), 256'(held_elen));
        chk("held_err_to",   256'(err_timeout), 256'(held_to));
        for (int j = 0; j < NJ; j++) job_data[j*W +: W] = job_w[j];
        start    = 1'b1;
        m_tready = tready_random ? 1'($urandom_range(0, 1)) : 1'b1;
        s_tvalid = 1'b0;

        while (!seen_done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            for (int j = 0; j < NJ; j++) job_data[j*W +: W] = $urandom;

            if (abort_after >= 0 && mbeats == abort_after) begin
                #2 aresetn = 1'b0;
                #1;
                chk("rst_m_tvalid", 256'(m_tvalid), 256'(0));
                chk("rst_busy",     256'(busy), 256'(0));
                chk("rst_done",     256'(done), 256'(0));
                chk("rst_s_tready", 256'(s_tready), 256'(0));
                chk("rst_result",   256'(result), 256'(0));
                repeat (2) begin
                    @(negedge clk);
                    chk("rst_no_done", 256'(done), 256'(0));
                end
                aresetn   = 1'b1;
                held_res  = '0;
                held_elen = 1'b0;
                held_to   = 1'b0;
                return;
            end

            m_tready = tready_random ? 1'($urandom_range(0, 1)) : 1'b1;
            if (cyc == 1) chk("first_tvalid_cycle1", 256'(m_tvalid), 256'(1));

            if (s_tready) begin
                recv_cycles++;
                chk("recv_no_m_tvalid", 256'(m_tvalid), 256'(0));
                if (pi < plan_data.size() && idle == plan_gap[pi]) begin
                    s_tvalid = 1'b1;
                    s_tdata  = plan_data[pi];
                    s_tlast  = plan_last[pi];
                    pi++;
                    idle = 0;
                end else begin
                    s_tvalid = 1'b0;
                    s_tdata  = $urandom;
                    s_tlast  = 1'($urandom_range(0, 1));
                    idle++;
                end
                if (poke_recv && recv_cycles == 2) start = 1'b1;
            end else begin
                s_tvalid = 1'b0;
                s_tlast  = 1'b0;
            end

            if (m_tvalid) begin
                if (prev_stall) begin
                    chk("stall_tdata", 256'(m_tdata), 256'(prev_data));
                    chk("stall_tlast", 256'(m_tlast), 256'(prev_last));
                end
                if (m_tready) begin
                    chk("no_extra_beat", 256'(mbeats < NJ), 256'(1));
                    if (mbeats < NJ) begin
                        chk($sformatf("beat%0d_tdata", mbeats), 256'(m_tdata), 256'(job_w[mbeats]));
                        chk($sformatf("beat%0d_tlast", mbeats), 256'(m_tlast), 256'(mbeats == NJ - 1));
                    end
                    mbeats++;
                    last_beat_cyc = cyc;
                end
                prev_stall = !m_tready;
                prev_data  = m_tdata;
                prev_last  = m_tlast;
            end else begin
                prev_stall = 1'b0;
            end

            if (done) begin
                seen_done = 1'b1;
                chk("done_job_beats",   256'(mbeats), 256'(NJ));
                chk("done_recv_cycles", 256'(recv_cycles), 256'(e_cycles));
                chk("done_busy",        256'(busy), 256'(1));
                chk("done_s_tready",    256'(s_tready), 256'(0));
                chk("done_result",      256'(result), 256'(e_res));
                chk("done_err_len",     256'(err_len), 256'(e_elen));
                chk("done_err_timeout", 256'(err_timeout), 256'(e_to));
                if (!tready_random) chk("last_beat_cycle20", 256'(last_beat_cyc), 256'(NJ));
            end
        end
        chk("done_seen", 256'(seen_done), 256'(1));
        s_tvalid  = 1'b0;
        held_res  = e_res;
        held_elen = e_elen;
        held_to   = e_to;
    endtask

    initial begin
        int n, lastpos, g;

        aresetn = 1'b0; start = 1'b0; job_data = '0; m_tready = 1'b0;
        s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; s_tstrb = '1;
        held_res = '0; held_elen = 1'b0; held_to = 1'b0; tready_random = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("reset_busy",     256'(busy), 256'(0));
        chk("reset_done",     256'(done), 256'(0));
        chk("reset_m_tvalid", 256'(m_tvalid), 256'(0));
        chk("reset_m_tlast",  256'(m_tlast), 256'(0));
        chk("reset_m_tdata",  256'(m_tdata), 256'(0));
        chk("reset_m_tstrb",  256'(m_tstrb), 256'(4'hF));
        chk("reset_s_tready", 256'(s_tready), 256'(0));
        chk("reset_err_len",  256'(err_len), 256'(0));
        chk("reset_err_to",   256'(err_timeout), 256'(0));
        chk("reset_result",   256'(result), 256'(0));
        aresetn = 1'b1;

        // Nominal job: counting header, ready always high, 0xA0..0xA7.
        tready_random = 1'b0;
        set_job(1'b1);
        clear_plan();
        for (int k = 0; k < NR; k++) add_beat(32'hA0 + 32'(k), k == NR - 1, 0);
        run_job(-1, 1'b0);

        // Master backpressure with random responder gaps.
        tready_random = 1'b1;
        set_job(1'b0);
        clear_plan();
        for (int k = 0; k < NR; k++) add_beat($urandom, k == NR - 1, $urandom_range(0, 4));
        run_job(-1, 1'b0);

        // Short result: 5 words, tlast on the 5th.
        tready_random = 1'b0;
        set_job(1'b0);
        clear_plan();
        for (int k = 0; k < 5; k++) add_beat($urandom, k == 4, $urandom_range(0, 3));
        run_job(-1, 1'b0);

        // Missing tlast: nine words offered, none flagged last.
        set_job(1'b0);
        clear_plan();
        for (int k = 0; k < NR + 1; k++) add_beat($urandom, 1'b0, 0);
        run_job(-1, 1'b0);

        // Timeout: silent after 3 words.
        set_job(1'b0);
        clear_plan();
        for (int k = 0; k < 3; k++) add_beat($urandom, 1'b0, 1);
        run_job(-1, 1'b0);

        // Beat exactly in the threshold cycle: accepted, no timeout.
        set_job(1'b0);
        clear_plan();
        for (int k = 0; k < NR; k++) add_beat($urandom, k == NR - 1, (k == 3) ? T - 1 : 0);
        run_job(-1, 1'b0);

        // One idle cycle later the timeout fires first.
        set_job(1'b0);
        clear_plan();
        for (int k = 0; k < NR; k++) add_beat($urandom, k == NR - 1, (k == 3) ? T : 0);
        run_job(-1, 1'b0);

        // Start pulsed during RECV is ignored.
        tready_random = 1'b1;
        set_job(1'b0);
        clear_plan();
        for (int k = 0; k < NR; k++) add_beat($urandom, k == NR - 1, 1);
        run_job(-1, 1'b1);

        // Reset after 7 job beats, then a fresh job from word 0.
        set_job(1'b0);
        run_job(7, 1'b0);
        set_job(1'b0);
        run_job(-1, 1'b0);

        // Randomized jobs.
        repeat (8) begin
            tready_random = 1'($urandom_range(0, 1));
            set_job(1'b0);
            clear_plan();
            n       = $urandom_range(1, NR + 1);
            lastpos = $urandom_range(0, NR + 1);
            for (int k = 0; k < n; k++) begin
                g = ($urandom_range(0, 7) == 0) ? $urandom_range(T - 1, T + 1) : $urandom_range(0, 3);
                add_beat($urandom, k == lastpos, g);
            end
            run_job(-1, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
